mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Program sequencer for the 1-bit ICU.
- Owns the program counter, fetches words from external asynchronous program memory, and presents opcodes to the ICU.
- Acts on the ICU's jmp/rtn/flag_f/flag_o decodes.
- Provides a hardware return stack, plus run/step/halt control for the host.

Parameters:
AW, 8, program address width; operand field width; PC wraps mod 2^AW
DEPTH, 4, return-stack entries (>=1)

Ports:
clk  in  1  clock; PC/state update on posedge
rst  in  1  reset, synchronous, active-low
start  in  1  pulse: run continuously from current PC
step  in  1  pulse: execute exactly one instruction
halt_req  in  1  pulse: stop after current instruction
prog_addr  out  AW  program memory address (= PC)
prog_data  in  4+AW  {opcode[3:0], operand[AW-1:0]}, combinational read
instruction  out  4  opcode to ICU (instruction_t)
io_addr  out  AW  operand field of prog_data, to I/O decode
icu_rst  out  1  active-high ICU reset = ~rst
icu_jmp, icu_rtn, icu_flag_f, icu_flag_o  in  1 each  ICU decodes
icu_skip  in  1  ICU skip_register (ICU exports it as an added output)
running  out  1  state is RUN or STEP
halted  out  1  state is HALT
halt_cause  out  2  0 none, 1 NOPO, 2 halt_req, 3 stack underflow
stack_ovf  out  1  sticky, push while full
sp  out  $clog2(DEPTH+1)  stack depth

Behaviour:
- Reset (rst=0 at posedge): state IDLE, PC=0, sp=0, call_pending=0, stack_ovf=0, halt_cause=0. Outputs: running=0, halted=0, icu_rst=1.
- States: IDLE, RUN, STEP, HALT.
- instruction = prog_data opcode in RUN/STEP; otherwise the bubble NOPO (4'h0).
- Timing: PC changes at posedge; memory is valid by negedge, when the ICU latches the opcode. ICU decodes at posedge P therefore describe the word at the current PC, and prog_data operand is still that word's operand.
- Decodes are valid only when the state register at P is RUN or STEP and icu_skip=0. Otherwise they are ignored; bubbles and skipped words have no sequencer effect, but the PC still advances for a skipped word.
- Valid decode at P, priority order:
  - icu_jmp: if call_pending, push PC+1; if sp==DEPTH, drop the address and set stack_ovf, but the jump is still taken. PC<=operand. Clear call_pending.
  - icu_rtn: if sp>0, pop, PC<=top. If sp==0: PC<=PC+1, halt_cause=3, go HALT. Clear call_pending.
  - icu_flag_f: call_pending<=1 (repeated NOPF keeps it set). PC<=PC+1.
  - icu_flag_o: PC<=PC+1, halt_cause=1, go HALT.
  - otherwise: PC<=PC+1.
- ICU skips the word at the return address after RTN. Callers place a filler word after the JMP.
- IDLE: start -> RUN; step -> STEP; start wins if both asserted; halt_req ignored.
- RUN: halt_req -> HALT, halt_cause=2, after applying the current word's PC update. NOPO/underflow cause overrides halt_req if simultaneous.
- STEP: one posedge later apply the decode and go to IDLE, or to HALT on NOPO/underflow/halt_req.
- HALT: start -> RUN, step -> STEP, clearing halt_cause to 0. If halt_cause==3, start/step are ignored until reset.
- stack_ovf clears only on reset.
- Reset mid-run: immediate IDLE, PC=0, stack emptied. The ICU is simultaneously reset via icu_rst.

Decomposition:
- Package instructions: add AW default constant, seq_state_t enum, halt_cause_t enum (NONE, NOPO, REQ, UNF), and BUBBLE_OP = NOPO.
- One sub-module, mc_return_stack (LIFO: push, pop, data, sp, full, empty). Simultaneous push+pop cannot occur.

Test Plan:
- Reset, program {LD 3, OR 4, STO 5, NOPO}, start -> PC 0,1,2,3; halted=1, halt_cause=1, PC=4; ICU executed 4 words.
- Word 2 = JMP 0x10 -> PC sequence 0,1,2,0x10,0x11.
- Call: word 5 NOPF, word 6 JMP 0x20, word 0x20 RTN -> sp 1 at 0x20, PC returns to 7; word 7 skipped (icu_skip=1); sp=0.
- DEPTH=4 with five nested calls -> stack_ovf=1 on 5th, jump taken to target; RTN at sp=0 -> halted, halt_cause=3, start ignored.
- step pulse from IDLE at PC=8 -> exactly one instruction, back to IDLE, PC=9; halt_req during RUN -> HALT with halt_cause=2, then start resumes at next PC.
- SKZ with RR=0 followed by JMP 0x30 -> jmp ignored, PC increments; rst=0 mid-run -> PC=0, sp=0, IDLE next cycle.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared types for the 1-bit ICU program sequencer.
package mc_sequencer_pkg;

    localparam int unsigned AW_DEFAULT = 8;

    // ICU opcode set
    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        HC_NONE = 2'd0,
        HC_NOPO = 2'd1,
        HC_REQ  = 2'd2,
        HC_UNF  = 2'd3
    } halt_cause_t;

    // Opcode shown to the ICU whenever the sequencer is not executing
    localparam instruction_t BUBBLE_OP = NOPO;

endpackage

// File: rtl/mc_sequencer_if.sv
// Program-memory and ICU bus between the sequencer and its neighbours.
interface mc_sequencer_if #(parameter int unsigned AW = 8);
    import mc_sequencer_pkg::*;

    logic [AW-1:0] prog_addr;
    logic [AW+3:0] prog_data;
    instruction_t  instruction;
    logic [AW-1:0] io_addr;
    logic          icu_rst;
    logic          icu_jmp;
    logic          icu_rtn;
    logic          icu_flag_f;
    logic          icu_flag_o;
    logic          icu_skip;

    modport master (
        output prog_addr, instruction, io_addr, icu_rst,
        input  prog_data, icu_jmp, icu_rtn, icu_flag_f, icu_flag_o, icu_skip
    );

    modport slave (
        input  prog_addr, instruction, io_addr, icu_rst,
        output prog_data, icu_jmp, icu_rtn, icu_flag_f, icu_flag_o, icu_skip
    );
endinterface

// File: rtl/mc_return_stack.sv
// Hardware LIFO of return addresses; pushes while full are dropped.
module mc_return_stack #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    output logic [AW-1:0]                top_data,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign wr_idx   = IW'(sp);
    assign rd_idx   = IW'(sp - 1'b1);
    assign top_data = empty ? '0 : mem[rd_idx];

    // Stack pointer: reset empties the stack
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Entry storage, written only by an accepted push
    always_ff @(posedge clk) begin
        if (rst && push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end
endmodule

// File: rtl/mc_sequencer.sv
// Program sequencer for the 1-bit ICU: PC, fetch, call/return and host run control.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        step,
    input  logic                        halt_req,
    mc_sequencer_if.master              bus,
    output logic                        running,
    output logic                        halted,
    output logic [1:0]                  halt_cause,
    output logic                        stack_ovf,
    output logic [$clog2(DEPTH+1)-1:0]  sp
);
    seq_state_t   state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          call_q, call_d;
    halt_cause_t   cause_q, cause_d;
    halt_cause_t   stop_cause;
    logic          ovf_set;

    logic          push, pop;
    logic          stk_full, stk_empty;
    logic [AW-1:0] stk_top;

    instruction_t  opcode;
    logic [AW-1:0] operand;
    logic [AW-1:0] pc_inc;
    logic          exec_active;
    logic          decode_ok;

    assign opcode      = instruction_t'(bus.prog_data[AW+3:AW]);
    assign operand     = bus.prog_data[AW-1:0];
    assign pc_inc      = pc_q + 1'b1;
    assign exec_active = (state_q == S_RUN) || (state_q == S_STEP);
    // ICU decodes describe the word at the current PC; skipped words carry no effect
    assign decode_ok   = exec_active && !bus.icu_skip;

    mc_return_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .sp        (sp),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // State, PC and sticky status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            call_q    <= 1'b0;
            cause_q   <= HC_NONE;
            stack_ovf <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            call_q    <= call_d;
            cause_q   <= cause_d;
            stack_ovf <= stack_ovf | ovf_set;
        end
    end

    // Next-state, PC update and stack control
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        call_d     = call_q;
        cause_d    = cause_q;
        stop_cause = HC_NONE;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end

            S_RUN, S_STEP: begin
                pc_d = pc_inc;
                if (decode_ok) begin
                    if (bus.icu_jmp) begin
                        if (call_q) begin
                            if (stk_full) begin
                                ovf_set = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        pc_d   = operand;
                        call_d = 1'b0;
                    end else if (bus.icu_rtn) begin
                        call_d = 1'b0;
                        if (!stk_empty) begin
                            pop  = 1'b1;
                            pc_d = stk_top;
                        end else begin
                            stop_cause = HC_UNF;
                        end
                    end else if (bus.icu_flag_f) begin
                        call_d = 1'b1;
                    end else if (bus.icu_flag_o) begin
                        stop_cause = HC_NOPO;
                    end
                end

                // Program-caused stops take precedence over a host halt request
                if (stop_cause != HC_NONE) begin
                    state_d = S_HALT;
                    cause_d = stop_cause;
                end else if (halt_req) begin
                    state_d = S_HALT;
                    cause_d = HC_REQ;
                end else if (state_q == S_STEP) begin
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                // Underflow is fatal until reset
                if (cause_q != HC_UNF) begin
                    if (start) begin
                        state_d = S_RUN;
                        cause_d = HC_NONE;
                    end else if (step) begin
                        state_d = S_STEP;
                        cause_d = HC_NONE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.prog_addr   = pc_q;
    assign bus.io_addr     = operand;
    assign bus.icu_rst     = ~rst;
    assign bus.instruction = exec_active ? opcode : BUBBLE_OP;

    assign running    = exec_active;
    assign halted     = (state_q == S_HALT);
    assign halt_cause = cause_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed scenarios plus a random run
// checked against an instruction-level interpreter.
module tb_mc_sequencer;
    import mc_sequencer_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       halt_req = 1'b0;
    logic       running, halted, stack_ovf;
    logic [1:0] halt_cause;
    logic [2:0] sp;

    int tests = 0;
    int fails = 0;

    mc_sequencer_if #(.AW(AW)) bus ();

    mc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .bus        (bus),
        .running    (running),
        .halted     (halted),
        .halt_cause (halt_cause),
        .stack_ovf  (stack_ovf),
        .sp         (sp)
    );

    always #5 clk = ~clk;

    // Asynchronous program memory
    logic [AW+3:0] mem [256];
    assign bus.prog_data = mem[bus.prog_addr];

    // Minimal ICU: latches opcode at negedge, decodes it, keeps RR and skip
    logic [3:0] ir = 4'h0;
    logic       skip_r = 1'b0;
    logic       rr = 1'b0;
    int         exec_cnt = 0;

    always @(negedge clk) ir <= bus.instruction;

    assign bus.icu_jmp    = (ir == 4'hC);
    assign bus.icu_rtn    = (ir == 4'hD);
    assign bus.icu_flag_f = (ir == 4'hF);
    assign bus.icu_flag_o = (ir == 4'h0);
    assign bus.icu_skip   = skip_r;

    always @(posedge clk) begin
        if (bus.icu_rst) begin
            skip_r   <= 1'b0;
            rr       <= 1'b0;
            exec_cnt <= 0;
        end else begin
            if (!skip_r && ir == 4'h1) rr <= bus.io_addr[0];
            skip_r <= !skip_r && (ir == 4'hD || (ir == 4'hE && !rr));
            if (running && !skip_r) exec_cnt <= exec_cnt + 1;
        end
    end

    // Reference interpreter: mode 0 idle, 1 run, 2 step, 3 halt
    int m_pc = 0;
    int m_mode = 0;
    int m_cause = 0;
    int m_stack [$];
    bit m_cp = 0;
    bit m_ovf = 0;

    task automatic model_tick();
        logic [11:0] word;
        int op, opnd, stop;
        if (!rst) begin
            m_mode = 0; m_pc = 0; m_cause = 0; m_cp = 0; m_ovf = 0;
            m_stack.delete();
        end else begin
            case (m_mode)
                0: begin
                    if (start) m_mode = 1;
                    else if (step) m_mode = 2;
                end
                1, 2: begin
                    word = mem[m_pc];
                    op   = int'(word[11:8]);
                    opnd = int'(word[7:0]);
                    stop = 0;
                    if (skip_r) begin
                        m_pc = (m_pc + 1) & 255;
                    end else if (op == 'hC) begin
                        if (m_cp) begin
                            if (m_stack.size() == DEPTH) m_ovf = 1;
                            else m_stack.push_back((m_pc + 1) & 255);
                        end
                        m_pc = opnd;
                        m_cp = 0;
                    end else if (op == 'hD) begin
                        m_cp = 0;
                        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                        else begin m_pc = (m_pc + 1) & 255; stop = 3; end
                    end else begin
                        if (op == 'hF) m_cp = 1;
                        if (op == 'h0) stop = 1;
                        m_pc = (m_pc + 1) & 255;
                    end
                    if (stop != 0) begin m_mode = 3; m_cause = stop; end
                    else if (halt_req) begin m_mode = 3; m_cause = 2; end
                    else if (m_mode == 2) m_mode = 0;
                end
                default: begin
                    if (m_cause != 3) begin
                        if (start) begin m_mode = 1; m_cause = 0; end
                        else if (step) begin m_mode = 2; m_cause = 0; end
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [11:0] w;
        bit run_exp;
        w = mem[m_pc];
        run_exp = (m_mode == 1) || (m_mode == 2);
        chk("pc", 32'(bus.prog_addr), 32'(m_pc));
        chk("sp", 32'(sp), 32'(m_stack.size()));
        chk("running", 32'(running), 32'(run_exp));
        chk("halted", 32'(halted), 32'(m_mode == 3));
        chk("halt_cause", 32'(halt_cause), 32'(m_cause));
        chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
        chk("icu_rst", 32'(bus.icu_rst), 32'(!rst));
        chk("instruction", 32'(bus.instruction), run_exp ? 32'(w[11:8]) : 32'h0);
    endtask

    // Called at posedge+1: drive inputs, predict just before the edge, compare after it
    task automatic tick(input bit s, input bit st, input bit h, input bit r);
        start = s; step = st; halt_req = h; rst = r;
        #8;
        model_tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic fill(input logic [11:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) tick(0, 0, 0, 1);
        chk("halt_within_budget", 32'(halted), 32'h1);
    endtask

    task automatic run_until_pc(input int target, input int budget);
        for (int i = 0; i < budget && int'(bus.prog_addr) != target; i++) tick(0, 0, 0, 1);
        chk("pc_reached", 32'(bus.prog_addr), 32'(target));
    endtask

    initial begin
        int exp_seq [5];

        @(posedge clk);
        #1;

        // Reset state and straight-line program ending in NOPO
        fill(12'h100);
        mem[0] = 12'h103; mem[1] = 12'h504; mem[2] = 12'h805; mem[3] = 12'h000;
        do_reset();
        chk("rst_pc", 32'(bus.prog_addr), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_icu_rst", 32'(bus.icu_rst), 32'h1);
        tick(1, 0, 0, 1);
        chk("run_pc0", 32'(bus.prog_addr), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0, 1);
            chk("run_pc_seq", 32'(bus.prog_addr), 32'(i));
        end
        tick(0, 0, 0, 1);
        chk("nopo_halted", 32'(halted), 32'h1);
        chk("nopo_cause", 32'(halt_cause), 32'h1);
        chk("nopo_pc", 32'(bus.prog_addr), 32'h4);
        chk("icu_exec_cnt", 32'(exec_cnt), 32'h4);

        // Plain jump
        fill(12'h100);
        mem[2] = 12'hC10; mem[8'h11] = 12'h000;
        do_reset();
        exp_seq = '{0, 1, 2, 16, 17};
        tick(1, 0, 0, 1);
        chk("jmp_seq", 32'(bus.prog_addr), 32'(exp_seq[0]));
        for (int i = 1; i < 5; i++) begin
            tick(0, 0, 0, 1);
            chk("jmp_seq", 32'(bus.prog_addr), 32'(exp_seq[i]));
        end
        run_until_halt(4);
        chk("jmp_end_pc", 32'(bus.prog_addr), 32'h12);

        // Call and return with skipped filler word
        fill(12'h100);
        mem[5] = 12'hF00; mem[6] = 12'hC20; mem[8] = 12'h000; mem[8'h20] = 12'hD00;
        do_reset();
        tick(1, 0, 0, 1);
        run_until_pc(8'h20, 20);
        chk("call_sp", 32'(sp), 32'h1);
        tick(0, 0, 0, 1);
        chk("ret_pc", 32'(bus.prog_addr), 32'h7);
        chk("ret_sp", 32'(sp), 32'h0);
        chk("ret_skip", 32'(skip_r), 32'h1);
        tick(0, 0, 0, 1);
        chk("after_skip_pc", 32'(bus.prog_addr), 32'h8);
        run_until_halt(4);
        chk("call_end_cause", 32'(halt_cause), 32'h1);

        // Five nested calls overflow a 4-deep stack, then unwind to underflow
        fill(12'h100);
        mem[8'h00] = 12'hF00; mem[8'h01] = 12'hC10;
        mem[8'h10] = 12'hF00; mem[8'h11] = 12'hC20;
        mem[8'h20] = 12'hF00; mem[8'h21] = 12'hC30;
        mem[8'h30] = 12'hF00; mem[8'h31] = 12'hC40;
        mem[8'h40] = 12'hF00; mem[8'h41] = 12'hC50;
        mem[8'h50] = 12'hD00;
        mem[8'h33] = 12'hD00; mem[8'h23] = 12'hD00; mem[8'h13] = 12'hD00; mem[8'h03] = 12'hD00;
        do_reset();
        tick(1, 0, 0, 1);
        run_until_pc(8'h50, 40);
        chk("ovf_flag", 32'(stack_ovf), 32'h1);
        chk("ovf_sp", 32'(sp), 32'h4);
        run_until_halt(40);
        chk("unf_cause", 32'(halt_cause), 32'h3);
        chk("unf_pc", 32'(bus.prog_addr), 32'h4);
        tick(1, 0, 0, 1);
        chk("unf_start_ignored", 32'(halted), 32'h1);
        tick(0, 1, 0, 1);
        chk("unf_step_ignored", 32'(halted), 32'h1);
        chk("ovf_sticky", 32'(stack_ovf), 32'h1);

        // Single step from IDLE, then halt_req during RUN and resume
        fill(12'h100);
        mem[0] = 12'hC08;
        do_reset();
        tick(0, 1, 0, 1);
        tick(0, 0, 0, 1);
        chk("step_to_8", 32'(bus.prog_addr), 32'h8);
        tick(0, 1, 0, 1);
        chk("step_running", 32'(running), 32'h1);
        tick(0, 0, 0, 1);
        chk("step_pc9", 32'(bus.prog_addr), 32'h9);
        chk("step_idle", 32'(running | halted), 32'h0);
        tick(0, 0, 0, 1);
        chk("idle_hold_pc", 32'(bus.prog_addr), 32'h9);
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 1, 1);
        chk("req_halted", 32'(halted), 32'h1);
        chk("req_cause", 32'(halt_cause), 32'h2);
        chk("req_pc", 32'(bus.prog_addr), 32'hB);
        tick(1, 0, 0, 1);
        chk("resume_cause", 32'(halt_cause), 32'h0);
        tick(0, 0, 0, 1);
        chk("resume_pc", 32'(bus.prog_addr), 32'hC);

        // SKZ with RR=0 suppresses the following JMP; then reset mid-run
        fill(12'h100);
        mem[0] = 12'h100; mem[1] = 12'hE00; mem[2] = 12'hC30;
        mem[3] = 12'hF00; mem[4] = 12'hC40;
        do_reset();
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("skz_pc", 32'(bus.prog_addr), 32'h3);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("pre_rst_sp", 32'(sp), 32'h1);
        tick(0, 0, 0, 0);
        chk("midrst_pc", 32'(bus.prog_addr), 32'h0);
        chk("midrst_sp", 32'(sp), 32'h0);
        chk("midrst_running", 32'(running), 32'h0);
        tick(0, 0, 0, 1);

        // Random programs and host pulses against the interpreter
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        for (int n = 0; n < 1500; n++) begin
            bit r;
            r = !(($urandom_range(0, 99) == 0) ||
                  (halted && halt_cause == 2'd3 && $urandom_range(0, 7) == 0));
            if (!r) for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
